dmem_responder: RTL and testbench

- Data-memory target that sits on the far side of the core's dmem request interface.
- Captures core requests on the clock edge; the core presents the next address and expects the RAM to buffer it.
- Holds an internal word-organised RAM with byte-lane writes.
- Returns read data aligned to bit 0 so the core's writeback sign/zero extension works unchanged.
- Inserts a configurable number of wait states through dmem_wait.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM target for the core dmem port with byte lanes and wait states
// Optional: define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module dmem_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dmem_address,
   input  logic        dmem_enable,
   input  logic [31:0] dmem_write_data,
   input  logic        dmem_write_enable,
   input  logic [2:0]  dmem_write_mode,
   input  logic        dmem_read_enable,
   input  logic [2:0]  dmem_read_mode,
   output logic [31:0] dmem_read_data,
   output logic        dmem_wait,
   output logic        misaligned_err,
   input  logic        err_clear
);
   localparam int AW    = ADDR_BITS + 2;
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [3:0]    wait_cnt;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [2:0]    req_wmode;
   logic [2:0]    req_rmode;
   logic          req_we;
   logic          req_re;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          fire;
   logic [AW-1:0] acc_addr;
   logic [31:0]   acc_wdata;
   logic [2:0]    acc_wmode;
   logic [2:0]    acc_rmode;
   logic          acc_we;
   logic          acc_re;

   logic          w_byte, w_half, w_word;
   logic          r_byte, r_half, r_word;
   logic [1:0]    w_off, r_off;
   logic          w_mis, r_mis;
   logic [3:0]    wr_be;
   logic [31:0]   wr_word;
   logic          wr_en;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic          unused_addr;

   assign unused_addr = ^dmem_address[31:AW];
   assign accept = (state == IDLE) && dmem_enable && (dmem_read_enable || dmem_write_enable);

   // With no wait states the access happens on the accept edge straight from the port.
   always_comb begin
      if (WAIT_STATES == 0) begin
         fire      = accept;
         acc_addr  = dmem_address[AW-1:0];
         acc_wdata = dmem_write_data;
         acc_wmode = dmem_write_mode;
         acc_rmode = dmem_read_mode;
         acc_we    = dmem_write_enable;
         acc_re    = dmem_read_enable;
      end else begin
         fire      = (state == BUSY) && (wait_cnt == 4'd0);
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wmode = req_wmode;
         acc_rmode = req_rmode;
         acc_we    = req_we;
         acc_re    = req_re;
      end
   end

   assign w_byte = (acc_wmode == 3'b000);
   assign w_half = (acc_wmode == 3'b001);
   assign w_word = (acc_wmode == 3'b010);
   assign r_byte = (acc_rmode[1:0] == 2'b00);
   assign r_half = (acc_rmode[1:0] == 2'b01);
   assign r_word = !r_byte && !r_half;

   assign w_off = w_word ? 2'b00 : (w_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
   assign r_off = r_word ? 2'b00 : (r_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = acc_we && ((w_half && acc_addr[0]) || (w_word && (acc_addr[1:0] != 2'b00)));
   assign r_mis = acc_re && ((r_half && acc_addr[0]) || (r_word && (acc_addr[1:0] != 2'b00)));
`else
   assign w_mis = 1'b0;
   assign r_mis = 1'b0;
`endif

   always_comb begin
      wr_be   = 4'b0000;
      wr_word = 32'd0;
      if (w_byte) begin
         wr_be   = 4'b0001 << w_off;
         wr_word = {4{acc_wdata[7:0]}};
      end else if (w_half) begin
         wr_be   = 4'b0011 << w_off;
         wr_word = {2{acc_wdata[15:0]}};
      end else if (w_word) begin
         wr_be   = 4'b1111;
         wr_word = acc_wdata;
      end
   end

   // Asynchronous read of the pre-write word gives read-before-write for combined requests.
   assign rd_word  = mem[acc_addr[AW-1:2]];
   assign rd_shift = rd_word >> {r_off, 3'b000};
   assign wr_en    = fire && acc_we && !w_mis && !reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[acc_addr[AW-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         wait_cnt       <= 4'd0;
         dmem_wait      <= 1'b0;
         dmem_read_data <= 32'd0;
         req_addr       <= '0;
         req_wdata      <= 32'd0;
         req_wmode      <= 3'd0;
         req_rmode      <= 3'd0;
         req_we         <= 1'b0;
         req_re         <= 1'b0;
      end else begin
         if (accept) begin
            req_addr  <= dmem_address[AW-1:0];
            req_wdata <= dmem_write_data;
            req_wmode <= dmem_write_mode;
            req_rmode <= dmem_read_mode;
            req_we    <= dmem_write_enable;
            req_re    <= dmem_read_enable;
         end
         if (state == IDLE) begin
            if (accept && (WAIT_STATES != 0)) begin
               state     <= BUSY;
               wait_cnt  <= WAIT_INIT;
               dmem_wait <= 1'b1;
            end
         end else begin
            if (wait_cnt == 4'd0) begin
               state     <= IDLE;
               dmem_wait <= 1'b0;
            end else begin
               wait_cnt <= wait_cnt - 4'd1;
            end
         end
         if (fire && acc_re) dmem_read_data <= r_mis ? 32'd0 : rd_shift;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) misaligned_err <= 1'b0;
      else if (fire && (w_mis || r_mis)) misaligned_err <= 1'b1;
      else if (err_clear) misaligned_err <= 1'b0;
   end
`else
   logic unused_clear;
   assign unused_clear   = err_clear;
   assign misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
// Three instances: default, WAIT_STATES=3, and ADDR_BITS=4/WAIT_STATES=2; honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata;
   logic        en, we, re, clr;
   logic [2:0]  wm, rm;
   logic [31:0] rd0, rd3, rd2;
   logic        w0, w3, w2, e0, e3, e2;
   logic        w0_seen = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int n;
   logic tog;
   logic [31:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) if (w0 === 1'b1) w0_seen <= 1'b1;

   dmem_responder u0 (
      .clk(clk), .reset(reset), .dmem_address(addr), .dmem_enable(en),
      .dmem_write_data(wdata), .dmem_write_enable(we), .dmem_write_mode(wm),
      .dmem_read_enable(re), .dmem_read_mode(rm), .dmem_read_data(rd0),
      .dmem_wait(w0), .misaligned_err(e0), .err_clear(clr));

   dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(3)) u3 (
      .clk(clk), .reset(reset), .dmem_address(addr), .dmem_enable(en),
      .dmem_write_data(wdata), .dmem_write_enable(we), .dmem_write_mode(wm),
      .dmem_read_enable(re), .dmem_read_mode(rm), .dmem_read_data(rd3),
      .dmem_wait(w3), .misaligned_err(e3), .err_clear(clr));

   dmem_responder #(.ADDR_BITS(4), .WAIT_STATES(2)) u2 (
      .clk(clk), .reset(reset), .dmem_address(addr), .dmem_enable(en),
      .dmem_write_data(wdata), .dmem_write_enable(we), .dmem_write_mode(wm),
      .dmem_read_enable(re), .dmem_read_mode(rm), .dmem_read_data(rd2),
      .dmem_wait(w2), .misaligned_err(e2), .err_clear(clr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      en = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
   endtask

   task automatic drive(input logic w, input logic r, input logic [2:0] wmd,
                        input logic [2:0] rmd, input logic [31:0] a, input logic [31:0] d);
      en = 1'b1; we = w; re = r; wm = wmd; rm = rmd; addr = a; wdata = d;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic st0(input logic [2:0] md, input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, md, 3'b010, a, d);
      cyc();
      idle_in();
   endtask

   task automatic ld0(input string tag, input logic [2:0] md, input logic [31:0] a,
                      input logic [31:0] exp);
      sb.push_back(exp);
      drive(1'b0, 1'b1, 3'b010, md, a, 32'd0);
      cyc();
      idle_in();
      chk(tag, rd0, sb.pop_front());
   endtask

   function automatic logic wait_of(input int s);
      return (s == 3) ? w3 : w2;
   endfunction

   // One access on a wait-state instance; n counts sampled cycles with dmem_wait high.
   task automatic accn(input int s, input logic w, input logic r, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] d, output int cnt);
      drive(w, r, md, md, a, d);
      cyc();
      idle_in();
      cnt = 0;
      while (wait_of(s) === 1'b1 && cnt < 20) begin
         cnt++;
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle_in();
      addr = 32'd0; wdata = 32'd0; wm = 3'd0; rm = 3'd0; tog = 1'b0;
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_wait0", w0, 1'b0);
      chk("rst_err0", e0, 1'b0);
      chk("rst_wait3", w3, 1'b0);
      chk("rst_rd2", rd2, 32'd0);

      st0(3'b010, 32'h10, 32'hDEADBEEF);
      ld0("ld_word_10", 3'b010, 32'h10, 32'hDEADBEEF);
      pulse_reset();
      chk("midrst_rd0", rd0, 32'd0);
      ld0("ld_after_rst_10", 3'b010, 32'h10, 32'hDEADBEEF);

      st0(3'b010, 32'h20, 32'h11223344);
      st0(3'b000, 32'h22, 32'h000000AA);
      st0(3'b001, 32'h20, 32'h0000BEEF);
      ld0("ld_word_20", 3'b010, 32'h20, 32'h11AABEEF);
      ld0("ld_byte_23", 3'b000, 32'h23, 32'h00000011);
      ld0("ld_half_22", 3'b001, 32'h22, 32'h000011AA);
      ld0("ld_byte100_21", 3'b100, 32'h21, 32'h0011AABE);
      ld0("ld_half101_22", 3'b101, 32'h22, 32'h000011AA);
      st0(3'b011, 32'h20, 32'h00000000);
      ld0("noop_wmode", 3'b010, 32'h20, 32'h11AABEEF);
      drive(1'b0, 1'b1, 3'b010, 3'b000, 32'h23, 32'd0);
      en = 1'b0;
      cyc();
      idle_in();
      chk("hold_en_low", rd0, 32'h11AABEEF);
      drive(1'b0, 1'b0, 3'b010, 3'b000, 32'h23, 32'd0);
      cyc();
      idle_in();
      chk("hold_no_rw", rd0, 32'h11AABEEF);

      st0(3'b010, 32'h40, 32'h00000005);
      sb.push_back(32'h00000005);
      drive(1'b1, 1'b1, 3'b010, 3'b010, 32'h40, 32'h00000009);
      cyc();
      idle_in();
      chk("rw_pre_write", rd0, sb.pop_front());
      ld0("rw_post_write", 3'b010, 32'h40, 32'h00000009);

      st0(3'b010, 32'h40, 32'h12345678);
      st0(3'b010, 32'h42, 32'hFFFFFFFF);
      chk("mis_err_set", e0, TRAP);
      st0(3'b001, 32'h41, 32'h0000CAFE);
      ld0("mis_word_40", 3'b010, 32'h40, TRAP ? 32'h12345678 : 32'hFFFFCAFE);
      chk("mis_err_sticky", e0, TRAP);
      ld0("mis_read_41", 3'b010, 32'h41, TRAP ? 32'h0 : 32'hFFFFCAFE);
      drive(1'b1, 1'b0, 3'b010, 3'b010, 32'h43, 32'h0BADF00D);
      clr = 1'b1;
      cyc();
      idle_in();
      chk("mis_set_wins", e0, TRAP);
      clr = 1'b1;
      cyc();
      idle_in();
      chk("mis_clear", e0, 1'b0);
      chk("u0_wait_never", w0_seen, 1'b0);

      pulse_reset();
      accn(3, 1'b1, 1'b0, 3'b010, 32'h34, 32'h0, n);
      chk("w3_st34_wait", n, 3);
      accn(3, 1'b1, 1'b0, 3'b010, 32'h30, 32'hA5A50003, n);
      chk("w3_st30_wait", n, 3);
      drive(1'b0, 1'b1, 3'b010, 3'b010, 32'h30, 32'd0);
      sb.push_back(32'hA5A50003);
      cyc();
      chk("w3_accept", w3, 1'b1);
      n = 1;
      while (w3 === 1'b1 && n < 20) begin
         tog = ~tog;
         drive(1'b1, 1'b0, 3'b010, 3'b010, 32'h34, 32'h00000BAD);
         en = tog;
         cyc();
         if (w3 === 1'b1) n++;
      end
      chk("w3_ld_wait", n, 3);
      chk("w3_ld_data", rd3, sb.pop_front());
      drive(1'b0, 1'b1, 3'b010, 3'b010, 32'h34, 32'd0);
      cyc();
      idle_in();
      chk("w3_next_accept", w3, 1'b1);
      n = 0;
      while (w3 === 1'b1 && n < 20) begin
         n++;
         cyc();
      end
      chk("w3_ld34_wait", n, 3);
      chk("w3_busy_ignored", rd3, 32'h0);

      pulse_reset();
      accn(2, 1'b1, 1'b0, 3'b010, 32'h04, 32'h11110000, n);
      chk("w2_st_wait", n, 2);
      drive(1'b1, 1'b0, 3'b010, 3'b010, 32'h04, 32'h22220000);
      cyc();
      idle_in();
      chk("w2_busy", w2, 1'b1);
      reset = 1'b1;
      cyc();
      chk("w2_rst_wait", w2, 1'b0);
      reset = 1'b0;
      accn(2, 1'b0, 1'b1, 3'b010, 32'h04, 32'h0, n);
      chk("w2_ld_wait", n, 2);
      chk("w2_not_committed", rd2, 32'h11110000);
      accn(2, 1'b1, 1'b0, 3'b010, 32'h44, 32'h33334444, n);
      accn(2, 1'b0, 1'b1, 3'b010, 32'h04, 32'h0, n);
      chk("w2_wrap", rd2, 32'h33334444);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
